y86_dmem: RTL and testbench

Y86_DMEM -- requirements
Module: y86_dmem

---
 rtl/y86_dmem.sv | 155 +++++++++++++++
 tb/tb_y86_dmem.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/y86_dmem.sv
// Y86 data memory: decodes the memory stage by icode, one request per cycle,
// fixed one-cycle response latency. Define DMEM_CLEAR_EN to zero the array after reset.
module y86_dmem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  output logic              ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error
);

  localparam logic [3:0] IC_RMMOVQ = 4'd4;
  localparam logic [3:0] IC_MRMOVQ = 4'd5;
  localparam logic [3:0] IC_CALL   = 4'd8;
  localparam logic [3:0] IC_RET    = 4'd9;
  localparam logic [3:0] IC_PUSHQ  = 4'd10;
  localparam logic [3:0] IC_POPQ   = 4'd11;

  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic              is_wr, is_rd, addr_ok, accept;
  logic [DATA_W-1:0] addr, wdata;
  logic [AW-1:0]     idx;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              resp_valid_q, resp_valid_d;
  logic              rd_ok_q, rd_ok_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] valm_hold_q, valm_hold_d;

  always_comb begin
    is_wr = 1'b0;
    is_rd = 1'b0;
    addr  = valE;
    wdata = valA;
    case (icode)
      IC_RMMOVQ, IC_PUSHQ: is_wr = 1'b1;
      IC_CALL: begin
        is_wr = 1'b1;
        wdata = valP;
      end
      IC_MRMOVQ, IC_POPQ: is_rd = 1'b1;
      IC_RET: begin
        is_rd = 1'b1;
        addr  = valA;
      end
      default: ;
    endcase
  end

  // Legality uses every address bit, so high garbage never aliases into the array.
  assign addr_ok = (addr < DEPTH_W);
  assign idx     = addr[AW-1:0];
  assign accept  = req & ready & ~rst;

`ifdef DMEM_CLEAR_EN
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  assign ready = (state_q == ST_RUN);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    mem_we    = accept & is_wr & addr_ok;
    mem_waddr = idx;
    mem_wdata = wdata;
    if (state_q == ST_CLEAR) begin
      mem_we    = ~rst;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end
  end
`else
  assign ready = 1'b1;

  always_comb begin
    mem_we    = accept & is_wr & addr_ok;
    mem_waddr = idx;
    mem_wdata = wdata;
  end
`endif

  // Single write port plus registered read keeps the array mappable to block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data_q <= mem[idx];
  end

  always_comb begin
    resp_valid_d = accept;
    rd_ok_d      = accept & is_rd & addr_ok;
    err_d        = accept & (is_rd | is_wr) & ~addr_ok;
  end

  // Reset masks the pending response immediately so nothing leaks out after it.
  always_comb begin
    resp_valid = resp_valid_q & ~rst;
    dmem_error = resp_valid & err_q;
    if (rst)               valM = '0;
    else if (resp_valid_q) valM = rd_ok_q ? rd_data_q : '0;
    else                   valM = valm_hold_q;
    valm_hold_d = valM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      rd_ok_q      <= 1'b0;
      err_q        <= 1'b0;
      valm_hold_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      rd_ok_q      <= rd_ok_d;
      err_q        <= err_d;
      valm_hold_q  <= valm_hold_d;
    end
  end

endmodule

// File: tb/tb_y86_dmem.sv
// Scoreboard bench for y86_dmem: directed requests push expected responses,
// a negedge monitor pops and compares them.
module tb_y86_dmem;
`ifdef DMEM_CLEAR_EN
  localparam int TB_DEPTH = 16;
  localparam longint CALL_A = 10;
`else
  localparam int TB_DEPTH = 1024;
  localparam longint CALL_A = 100;
`endif
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [3:0]    icode = 4'd0;
  logic [DW-1:0] valE = '0, valA = '0, valP = '0;
  logic          ready, resp_valid, dmem_error;
  logic [DW-1:0] valM;

  y86_dmem #(.DATA_W(DW), .DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .ready(ready), .resp_valid(resp_valid), .valM(valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] valm;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] last_valm = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every negedge, compare whatever the DUT presents against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_valM", valM, 64'd0);
      check("rst_dmem_error", {63'd0, dmem_error}, 64'd0);
      last_valm = '0;
    end else if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_valM", valM, e.valm);
        check("resp_err", {63'd0, dmem_error}, {63'd0, e.err});
        last_valm = e.valm;
      end
    end else begin
      if (dmem_error !== 1'b0) check("idle_err", {63'd0, dmem_error}, 64'd0);
      if (valM !== last_valm) check("idle_valM_hold", valM, last_valm);
    end
  end

  // Drives one request for one cycle; push_exp=0 means no response is expected.
  task automatic issue(input logic [3:0] ic, input logic [DW-1:0] e, input logic [DW-1:0] a,
                       input logic [DW-1:0] p, input logic [DW-1:0] xv, input logic xe,
                       input bit push_exp);
    exp_t x;
    req = 1'b1; icode = ic; valE = e; valA = a; valP = p;
    if (push_exp) begin
      x.valm = xv; x.err = xe;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    req = 1'b0;
    $display("req icode=%0d valE=0x%0h valA=0x%0h valP=0x%0h exp_valM=0x%0h exp_err=%0b",
             ic, e, a, p, xv, xe);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic count_ready_low(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      n++;
      if (n > 4 * TB_DEPTH + 10) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [DW-1:0] big;
    logic [DW-1:0] after_rst20;
    big = 64'h8000_0000_0000_0003;
`ifdef DMEM_CLEAR_EN
    after_rst20 = 64'd0;
`else
    after_rst20 = 64'h55;
`endif
    idle(2);
    @(negedge clk);
    check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset_valM", valM, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_ready_low(n);
`ifdef DMEM_CLEAR_EN
    check("clear_ready_low_cycles", 64'(n), 64'(TB_DEPTH));
    issue(4'd5, 64'd3, 0, 0, 64'd0, 1'b0, 1);
    idle(2);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(7);
    rst = 1'b1; idle(1); rst = 1'b0;
    count_ready_low(n);
    check("clear_restart_low_cycles", 64'(n), 64'(TB_DEPTH));
`else
    check("ready_after_reset", 64'(n), 64'd0);
`endif
    issue(4'd4, 64'd5, 64'hDEAD, 0, 64'd0, 1'b0, 1);
    issue(4'd5, 64'd5, 0, 0, 64'hDEAD, 1'b0, 1);
    issue(4'd8, CALL_A, 0, 64'h40, 64'd0, 1'b0, 1);
    issue(4'd9, 0, CALL_A, 0, 64'h40, 1'b0, 1);
    idle(3);
    issue(4'd4, 64'd0, 64'h77, 0, 64'd0, 1'b0, 1);
    issue(4'd10, 64'(TB_DEPTH), 64'h1234, 0, 64'd0, 1'b1, 1);
    issue(4'd11, 64'(TB_DEPTH), 0, 0, 64'd0, 1'b1, 1);
    issue(4'd4, big, 64'h999, 0, 64'd0, 1'b1, 1);
    issue(4'd5, 64'd0, 0, 0, 64'h77, 1'b0, 1);
    issue(4'd5, 64'd3, 0, 0, 64'd0, 1'b0, 1);
    issue(4'd0, 64'd5, 64'd5, 64'd5, 64'd0, 1'b0, 1);
    issue(4'd10, 64'd7, 64'hABC, 0, 64'd0, 1'b0, 1);
    issue(4'd11, 64'd7, 0, 0, 64'hABC, 1'b0, 1);
    issue(4'd6, 64'd7, 64'h1, 0, 64'd0, 1'b0, 1);
    issue(4'd9, 0, 64'd7, 0, 64'hABC, 1'b0, 1);
    idle(2);
    issue(4'd4, 64'd20, 64'h55, 0, 64'd0, 1'b0, 1);
    idle(1);
    // Accepted read immediately followed by reset: its response must never appear.
    req = 1'b1; icode = 4'd5; valE = 64'd20;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b1;
    // Write presented during reset must be ignored.
    req = 1'b1; icode = 4'd4; valE = 64'd20; valA = 64'h99;
    @(negedge clk);
    check("rst_after_req_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_after_req_valM", valM, 64'd0);
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b0;
    count_ready_low(n);
    issue(4'd5, 64'd20, 0, 0, after_rst20, 1'b0, 1);
    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
